// File: rtl/synth_pkg.sv
// Shared types and constants for the synth datapath: operand/phase widths,
// scheduler state encoding, and the per-voice pre-resolution rule.
package synth_pkg;

  localparam int CNT_W = 19;
  localparam int PH_W  = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SNAP    = 3'd1,
    LOAD    = 3'd2,
    WAIT    = 3'd3,
    STORE   = 3'd4,
    PUBLISH = 3'd5
  } sched_state_t;

  typedef struct packed {
    logic            launch;
    logic [PH_W-1:0] phase;
  } resolve_t;

  // Decide whether a voice needs the divider; if not, its phase is known now.
  function automatic resolve_t pre_resolve(input logic             en,
                                           input logic [CNT_W-1:0] cnt,
                                           input logic [CNT_W-1:0] dsor);
    resolve_t r;
    r.launch = 1'b0;
    r.phase  = {PH_W{1'b0}};
    if (!en) begin
      r.phase = {PH_W{1'b0}};
    end else if (dsor == {CNT_W{1'b0}}) begin
      r.phase = {PH_W{1'b0}};
    end else if (cnt >= dsor) begin
      r.phase = {PH_W{1'b1}};
    end else begin
      r.launch = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seqdiv_sched.sv
// Shares one seqdiv between NVOICE voices: snapshots operands on tick, runs one
// division per voice that needs it, then publishes every phase in a single cycle.
module seqdiv_sched
  import synth_pkg::*;
#(
  parameter int NVOICE  = 4,
  parameter int TIMEOUT = 40
) (
  input  logic                    clk,
  input  logic                    RST,
  input  logic                    tick,
  input  logic [NVOICE-1:0]       voice_en,
  input  logic [CNT_W*NVOICE-1:0] count_in,
  input  logic [CNT_W*NVOICE-1:0] dsor_in,
  output logic [CNT_W-1:0]        div_count,
  output logic [CNT_W-1:0]        div_dsor,
  output logic                    div_sample,
  input  logic [PH_W-1:0]         div_q,
  input  logic                    div_done,
  output logic [PH_W*NVOICE-1:0]  phase_out,
  output logic                    frame_done,
  output logic                    busy,
  output logic                    overrun,
  output logic                    timeout_err
);

  localparam int SLOT_W = (NVOICE > 1) ? $clog2(NVOICE) : 1;
  localparam int WC_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  sched_state_t state_q, state_d;
  logic [SLOT_W-1:0]                 idx_q, idx_d;
  logic [WC_W-1:0]                   wcnt_q, wcnt_d;
  logic [NVOICE-1:0]                 en_q, en_d;
  logic [NVOICE-1:0][CNT_W-1:0]      cnt_q, cnt_d, dsr_q, dsr_d;
  logic [NVOICE-1:0][PH_W-1:0]       res_q, res_d, phase_q, phase_d;
  logic [CNT_W-1:0]                  dcnt_q, dcnt_d, ddsr_q, ddsr_d;
  logic sample_q, sample_d, fdone_q, fdone_d, busy_q, busy_d, tout_q, tout_d;

  logic [SLOT_W-1:0] sel_idx;
  logic              sel_last;
  resolve_t          sel_res;

  // SNAP looks at slot 0; STORE looks at the slot after the one just finished.
  always_comb begin
    sel_idx  = {SLOT_W{1'b0}};
    sel_last = 1'b0;
    if (state_q == STORE) begin
      if (idx_q == SLOT_W'(NVOICE - 1)) begin
        sel_last = 1'b1;
      end else begin
        sel_idx = idx_q + 1'b1;
      end
    end else begin
      sel_idx = {SLOT_W{1'b0}};
    end
  end

  assign sel_res = pre_resolve(en_q[sel_idx], cnt_q[sel_idx], dsr_q[sel_idx]);

  // Next-state and datapath updates for the frame sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    dsr_d   = dsr_q;
    res_d   = res_q;
    phase_d = phase_q;
    fdone_d = 1'b0;
    tout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          en_d    = voice_en;
          cnt_d   = count_in;
          dsr_d   = dsor_in;
          idx_d   = {SLOT_W{1'b0}};
          state_d = SNAP;
        end else begin
          state_d = IDLE;
        end
      end
      SNAP, STORE: begin
        if (sel_last) begin
          state_d = PUBLISH;
        end else begin
          idx_d = sel_idx;
          if (sel_res.launch) begin
            state_d = LOAD;
          end else begin
            res_d[sel_idx] = sel_res.phase;
            state_d        = STORE;
          end
        end
      end
      LOAD: begin
        wcnt_d  = {WC_W{1'b0}};
        state_d = WAIT;
      end
      WAIT: begin
        if (div_done) begin
          res_d[idx_q] = div_q;
          state_d      = STORE;
        end else if (wcnt_q == WC_W'(TIMEOUT - 1)) begin
          // Abandon the slot so a stuck divider cannot stall the frame.
          res_d[idx_q] = {PH_W{1'b0}};
          tout_d       = 1'b1;
          state_d      = STORE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      PUBLISH: begin
        phase_d = res_q;
        fdone_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d   = (state_d != IDLE);
    sample_d = (state_d == LOAD);
    dcnt_d   = (state_d == LOAD) ? cnt_q[idx_d] : {CNT_W{1'b0}};
    ddsr_d   = (state_d == LOAD) ? dsr_q[idx_d] : {CNT_W{1'b0}};
  end

  // State, shadow operands, result buffer and registered outputs.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      idx_q    <= {SLOT_W{1'b0}};
      wcnt_q   <= {WC_W{1'b0}};
      en_q     <= {NVOICE{1'b0}};
      cnt_q    <= '0;
      dsr_q    <= '0;
      res_q    <= '0;
      phase_q  <= '0;
      dcnt_q   <= {CNT_W{1'b0}};
      ddsr_q   <= {CNT_W{1'b0}};
      sample_q <= 1'b0;
      fdone_q  <= 1'b0;
      busy_q   <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wcnt_q   <= wcnt_d;
      en_q     <= en_d;
      cnt_q    <= cnt_d;
      dsr_q    <= dsr_d;
      res_q    <= res_d;
      phase_q  <= phase_d;
      dcnt_q   <= dcnt_d;
      ddsr_q   <= ddsr_d;
      sample_q <= sample_d;
      fdone_q  <= fdone_d;
      busy_q   <= busy_d;
      tout_q   <= tout_d;
    end
  end

  assign div_count   = dcnt_q;
  assign div_dsor    = ddsr_q;
  assign div_sample  = sample_q;
  assign phase_out   = phase_q;
  assign frame_done  = fdone_q;
  assign busy        = busy_q;
  assign timeout_err = tout_q;
  // Flags the dropped tick in the same cycle it is presented.
  assign overrun     = tick & (state_q != IDLE);

endmodule
